// File: rtl/chrono_pkg.sv
// Shared types and constants for the chrono_display BCD/seven-segment front end.
// Segment constants are active-high {g..a}; output polarity is applied at the top.
package chrono_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_e;

   localparam int unsigned N_SHIFT = 10;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_BLANK = 7'h00;
   localparam logic [6:0] SEG_L     = 7'h38;

   // Double-dabble nibble correction applied before each shift.
   function automatic logic [3:0] add3(input logic [3:0] nib);
      return (nib >= 4'd5) ? nib + 4'd3 : nib;
   endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to active-high seven-segment {g..a} decoder.
// Codes 10..15 never occur in practice and decode to blank.
module bcd_to_7seg
   import chrono_pkg::*;
(
   input  logic [3:0] bcd_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      case (bcd_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/chrono_display.sv
// Stopwatch display: samples ms/sec, converts to BCD by double-dabble, drives "SS.mmm".
// Define CHRONO_DISPLAY_LZB_EN to blank HEX4 when the seconds tens digit is zero.
module chrono_display
   import chrono_pkg::*;
#(
   parameter bit          HEX_ACTIVE_LOW = 1'b1,
   parameter int unsigned MS_MAX         = 999,
   parameter int unsigned SEC_MAX        = 59
) (
   input  logic       ms_clk,
   input  logic       rst_a_p,
   input  logic [9:0] ms_counter,
   input  logic [5:0] second_counter,
   input  logic       lap,
   output logic       hold,
   output logic       conv_done,
   output logic [7:0] HEX0,
   output logic [7:0] HEX1,
   output logic [7:0] HEX2,
   output logic [7:0] HEX3,
   output logic [7:0] HEX4,
   output logic [7:0] HEX5
);

   localparam logic [9:0] MsMax   = 10'(MS_MAX);
   localparam logic [5:0] SecMax  = 6'(SEC_MAX);
   localparam logic [3:0] CntLast = 4'(N_SHIFT - 1);
   localparam logic [7:0] PolMask = HEX_ACTIVE_LOW ? 8'hFF : 8'h00;
`ifdef CHRONO_DISPLAY_LZB_EN
   localparam logic [7:0] Hex4Rst = {1'b0, SEG_BLANK};
`else
   localparam logic [7:0] Hex4Rst = {1'b0, SEG_0};
`endif

   state_e           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [9:0]       ms_bin_q, ms_bin_d, sec_bin_q, sec_bin_d;
   logic [11:0]      ms_bcd_q, ms_bcd_d, ms_adj;
   logic [7:0]       sec_bcd_q, sec_bcd_d, sec_adj;
   logic [4:0][3:0]  disp_q, disp_d;   // [4]=sec tens ... [0]=ms ones
   logic             hold_q, hold_d, lap_q, lap_edge;
   logic             conv_done_q;
   logic [5:0][7:0]  hex_raw_q, hex_raw_d;
   logic [4:0][6:0]  seg;
   logic [9:0]       ms_sat;
   logic [5:0]       sec_sat;

   assign ms_sat  = (ms_counter > MsMax) ? MsMax : ms_counter;
   assign sec_sat = (second_counter > SecMax) ? SecMax : second_counter;

   assign ms_adj  = {add3(ms_bcd_q[11:8]), add3(ms_bcd_q[7:4]), add3(ms_bcd_q[3:0])};
   assign sec_adj = {add3(sec_bcd_q[7:4]), add3(sec_bcd_q[3:0])};

   always_comb begin
      lap_edge  = lap & ~lap_q;
      hold_d    = hold_q ^ lap_edge;
      state_d   = state_q;
      cnt_d     = cnt_q;
      ms_bin_d  = ms_bin_q;
      sec_bin_d = sec_bin_q;
      ms_bcd_d  = ms_bcd_q;
      sec_bcd_d = sec_bcd_q;
      disp_d    = disp_q;
      unique case (state_q)
         IDLE: state_d = LOAD;
         LOAD: begin
            ms_bin_d  = ms_sat;
            sec_bin_d = {4'b0000, sec_sat};
            ms_bcd_d  = '0;
            sec_bcd_d = '0;
            cnt_d     = '0;
            state_d   = SHIFT;
         end
         SHIFT: begin
            // Correction carries out of the top nibble are dropped; inputs are range-limited.
            ms_bcd_d  = 12'({ms_adj, ms_bin_q[9]});
            sec_bcd_d = 8'({sec_adj, sec_bin_q[9]});
            ms_bin_d  = {ms_bin_q[8:0], 1'b0};
            sec_bin_d = {sec_bin_q[8:0], 1'b0};
            cnt_d     = cnt_q + 4'd1;
            if (cnt_q == CntLast) state_d = COMMIT;
         end
         COMMIT: begin
            if (!hold_d) begin
               disp_d = {sec_bcd_q[7:4], sec_bcd_q[3:0],
                         ms_bcd_q[11:8], ms_bcd_q[7:4], ms_bcd_q[3:0]};
            end
            state_d = LOAD;
         end
         default: state_d = IDLE;
      endcase
   end

   for (genvar i = 0; i < 5; i++) begin : g_dec
      bcd_to_7seg u_dec (
         .bcd_i (disp_d[i]),
         .seg_o (seg[i])
      );
   end

   // Segment registers load from next-state values so they track disp/hold with no extra lag.
   always_comb begin
      hex_raw_d[0] = {1'b0, seg[0]};
      hex_raw_d[1] = {1'b0, seg[1]};
      hex_raw_d[2] = {1'b0, seg[2]};
      hex_raw_d[3] = {1'b1, seg[3]};
`ifdef CHRONO_DISPLAY_LZB_EN
      hex_raw_d[4] = (disp_d[4] == 4'd0) ? {1'b0, SEG_BLANK} : {1'b0, seg[4]};
`else
      hex_raw_d[4] = {1'b0, seg[4]};
`endif
      hex_raw_d[5] = {1'b0, (hold_d ? SEG_L : SEG_BLANK)};
   end

   always_ff @(posedge ms_clk or posedge rst_a_p) begin
      if (rst_a_p) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         ms_bin_q     <= '0;
         sec_bin_q    <= '0;
         ms_bcd_q     <= '0;
         sec_bcd_q    <= '0;
         disp_q       <= '0;
         hold_q       <= 1'b0;
         lap_q        <= 1'b0;
         conv_done_q  <= 1'b0;
         hex_raw_q[0] <= {1'b0, SEG_0};
         hex_raw_q[1] <= {1'b0, SEG_0};
         hex_raw_q[2] <= {1'b0, SEG_0};
         hex_raw_q[3] <= {1'b1, SEG_0};
         hex_raw_q[4] <= Hex4Rst;
         hex_raw_q[5] <= {1'b0, SEG_BLANK};
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ms_bin_q    <= ms_bin_d;
         sec_bin_q   <= sec_bin_d;
         ms_bcd_q    <= ms_bcd_d;
         sec_bcd_q   <= sec_bcd_d;
         disp_q      <= disp_d;
         hold_q      <= hold_d;
         lap_q       <= lap;
         conv_done_q <= (state_d == COMMIT);
         hex_raw_q   <= hex_raw_d;
      end
   end

   assign hold      = hold_q;
   assign conv_done = conv_done_q;
   assign HEX0      = hex_raw_q[0] ^ PolMask;
   assign HEX1      = hex_raw_q[1] ^ PolMask;
   assign HEX2      = hex_raw_q[2] ^ PolMask;
   assign HEX3      = hex_raw_q[3] ^ PolMask;
   assign HEX4      = hex_raw_q[4] ^ PolMask;
   assign HEX5      = hex_raw_q[5] ^ PolMask;

endmodule

// File: tb/tb_chrono_display.sv
// Directed self-checking bench for chrono_display (default parameters, low-true segments).
// Honours CHRONO_DISPLAY_LZB_EN when computing the expected HEX4 pattern.
module tb_chrono_display;

   logic       ms_clk = 1'b0;
   logic       rst_a_p;
   logic [9:0] ms_counter;
   logic [5:0] second_counter;
   logic       lap;
   logic       hold, conv_done;
   logic [7:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

   int checks = 0;
   int errors = 0;
   int n;

   always #5 ms_clk = ~ms_clk;

   chrono_display u_dut (
      .ms_clk         (ms_clk),
      .rst_a_p        (rst_a_p),
      .ms_counter     (ms_counter),
      .second_counter (second_counter),
      .lap            (lap),
      .hold           (hold),
      .conv_done      (conv_done),
      .HEX0           (HEX0),
      .HEX1           (HEX1),
      .HEX2           (HEX2),
      .HEX3           (HEX3),
      .HEX4           (HEX4),
      .HEX5           (HEX5)
   );

   // Expected low-true {dp, g..a} pattern for a decimal digit.
   function automatic logic [7:0] enc(input int d, input logic dp);
      logic [6:0] s;
      case (d)
         0: s = 7'b0111111;
         1: s = 7'b0000110;
         2: s = 7'b1011011;
         3: s = 7'b1001111;
         4: s = 7'b1100110;
         5: s = 7'b1101101;
         6: s = 7'b1111101;
         7: s = 7'b0000111;
         8: s = 7'b1111111;
         9: s = 7'b1101111;
         default: s = 7'b0000000;
      endcase
      return ~{dp, s};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_disp(input string tag, input int st, input int so, input int mh,
                             input int mt, input int mo, input logic exp_hold);
      logic [7:0] exp4;
      exp4 = enc(st, 1'b0);
`ifdef CHRONO_DISPLAY_LZB_EN
      if (st == 0) exp4 = 8'hFF;
`endif
      chk({tag, ".hex0"}, 32'(HEX0), 32'(enc(mo, 1'b0)));
      chk({tag, ".hex1"}, 32'(HEX1), 32'(enc(mt, 1'b0)));
      chk({tag, ".hex2"}, 32'(HEX2), 32'(enc(mh, 1'b0)));
      chk({tag, ".hex3"}, 32'(HEX3), 32'(enc(so, 1'b1)));
      chk({tag, ".hex4"}, 32'(HEX4), 32'(exp4));
      chk({tag, ".hex5"}, 32'(HEX5), exp_hold ? 32'h0000_00C7 : 32'h0000_00FF);
      chk({tag, ".hold"}, 32'(hold), 32'(exp_hold));
   endtask

   // Returns at the negedge where conv_done is seen (COMMIT cycle); n = negedges waited.
   task automatic wait_conv(input string tag, output int cnt);
      cnt = 0;
      while (cnt < 40) begin
         @(negedge ms_clk);
         cnt++;
         if (conv_done) break;
      end
      if (!conv_done) begin
         checks++;
         errors++;
         $error("FAIL %s conv_done timeout observed=0 expected=1", tag);
      end
   endtask

   // Returns one cycle after COMMIT: new value visible, DUT is about to sample in LOAD.
   task automatic next_commit(input string tag);
      int c;
      wait_conv(tag, c);
      @(negedge ms_clk);
   endtask

   task automatic set_in(input int ms, input int sec);
      ms_counter     = 10'(ms);
      second_counter = 6'(sec);
   endtask

   initial begin
      rst_a_p = 1'b1;
      lap     = 1'b0;
      set_in(0, 0);
      #2;
      check_disp("rst", 0, 0, 0, 0, 0, 1'b0);
      chk("rst.conv_done", 32'(conv_done), 32'd0);
      @(negedge ms_clk);
      rst_a_p = 1'b0;

      // IDLE, LOAD, 10 SHIFT: COMMIT is the 12th cycle after release, then every 12.
      wait_conv("first", n);
      chk("first_latency", 32'(n), 32'd12);
      wait_conv("period", n);
      chk("conv_period", 32'(n), 32'd12);
      @(negedge ms_clk);
      chk("conv_done_pulse", 32'(conv_done), 32'd0);
      check_disp("zero", 0, 0, 0, 0, 0, 1'b0);

      set_in(999, 59);
      next_commit("max");
      check_disp("max", 5, 9, 9, 9, 9, 1'b0);
      next_commit("max2");
      check_disp("max2", 5, 9, 9, 9, 9, 1'b0);

      set_in(307, 8);
      next_commit("v307");
      check_disp("v307", 0, 8, 3, 0, 7, 1'b0);

      // Lap held for several cycles mid-SHIFT: exactly one toggle into hold.
      repeat (4) @(negedge ms_clk);
      lap = 1'b1;
      @(negedge ms_clk);
      chk("lap_on.hold", 32'(hold), 32'd1);
      chk("lap_on.hex5", 32'(HEX5), 32'h0000_00C7);
      repeat (2) @(negedge ms_clk);
      chk("lap_held.hold", 32'(hold), 32'd1);
      lap = 1'b0;
      set_in(512, 30);
      next_commit("frz1");
      next_commit("frz2");
      check_disp("frozen", 0, 8, 3, 0, 7, 1'b1);

      repeat (4) @(negedge ms_clk);
      lap = 1'b1;
      @(negedge ms_clk);
      lap = 1'b0;
      chk("lap_off.hold", 32'(hold), 32'd0);
      chk("lap_off.hex5", 32'(HEX5), 32'h0000_00FF);
      next_commit("v512");
      check_disp("v512", 3, 0, 5, 1, 2, 1'b0);

      // Lap edges landing exactly on COMMIT.
      set_in(111, 11);
      next_commit("v111");
      check_disp("v111", 1, 1, 1, 1, 1, 1'b0);
      set_in(345, 12);
      wait_conv("enter_c", n);
      lap = 1'b1;
      @(negedge ms_clk);
      lap = 1'b0;
      check_disp("enter_commit", 1, 1, 1, 1, 1, 1'b1);
      wait_conv("leave_c", n);
      lap = 1'b1;
      @(negedge ms_clk);
      lap = 1'b0;
      check_disp("leave_commit", 1, 2, 3, 4, 5, 1'b0);

      set_in(1023, 63);
      next_commit("sat");
      check_disp("sat", 5, 9, 9, 9, 9, 1'b0);

      // Asynchronous reset mid-SHIFT while held.
      set_in(678, 45);
      next_commit("v678");
      check_disp("v678", 4, 5, 6, 7, 8, 1'b0);
      repeat (3) @(negedge ms_clk);
      lap = 1'b1;
      @(negedge ms_clk);
      lap = 1'b0;
      chk("pre_rst.hold", 32'(hold), 32'd1);
      repeat (2) @(negedge ms_clk);
      rst_a_p = 1'b1;
      #1;
      check_disp("mid_rst", 0, 0, 0, 0, 0, 1'b0);
      chk("mid_rst.conv_done", 32'(conv_done), 32'd0);
      @(negedge ms_clk);
      rst_a_p = 1'b0;
      wait_conv("post_rst", n);
      chk("post_rst_latency", 32'(n), 32'd12);
      @(negedge ms_clk);
      check_disp("post_rst", 4, 5, 6, 7, 8, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/chrono_display.md
Name: chrono_display

Overview:
Downstream consumer of the stopwatch counter. It samples the ms (0..999) and seconds (0..59) binary counts and converts them to BCD with an iterative shift-add-3 (double-dabble) engine. It drives six DE10-Lite style seven-segment digits as "SS.mmm". A lap input freezes the shown value while the counter keeps running.

Parameters:
HEX_ACTIVE_LOW, 1, 1 = segment/dp outputs low-true (board default); 0 = inverted polarity
MS_MAX, 999, input ms value above this saturates to MS_MAX before conversion
SEC_MAX, 59, input seconds value above this saturates to SEC_MAX before conversion

Ports:
ms_clk  in  1  1 kHz tick clock from the clock divider
rst_a_p  in  1  reset, asynchronous, active-high
ms_counter  in  10  binary milliseconds from the stopwatch counter
second_counter  in  6  binary seconds from the stopwatch counter
lap  in  1  debounced lap request, sync to ms_clk; rising edge toggles hold
hold  out  1  1 = display frozen (lap view)
conv_done  out  1  one-cycle pulse when a conversion commits (also when suppressed by hold)
HEX0..HEX5  out  8 each  {dp, g..a}; HEX0 = ms ones ... HEX4 = sec tens, HEX5 = lap indicator

Behaviour:
- Reset (async, rst_a_p=1): state=IDLE, shift counter=0, disp BCD digits all 0, hold=0, lap_q=0, conv_done=0. Outputs show "00.000"; HEX5 is blank; only the HEX3 dp is lit.
- FSM, one transition per ms_clk:
  - IDLE: go to LOAD next cycle (free-running).
  - LOAD: latch sat(ms_counter) and zero-extended sat(second_counter) (10 bits each) into shift registers; clear BCD scratch; cnt=0.
  - SHIFT: each cycle, first add 3 to every scratch BCD nibble >=5, then shift left 1 pulling in the binary MSB; cnt++. Leave after cnt reaches 9 (10 shifts) -> COMMIT.
  - COMMIT: if hold_next=0, copy scratch (sec tens/ones, ms hundreds/tens/ones) into disp registers. Pulse conv_done. Go to LOAD.
- Period is 12 cycles (LOAD + 10 SHIFT + COMMIT). Displayed value lags the sampled input by 11 cycles. Inputs are sampled only in LOAD.
- Width rules:
  - ms scratch = 12 bits (3 nibbles); sec scratch = 8 bits (2 nibbles).
  - The seconds path uses the same 10-shift schedule (4 leading zeros), so one shared counter serves both paths.
- Saturation: ms_counter>MS_MAX converts as MS_MAX; second_counter>SEC_MAX converts as SEC_MAX.
- Lap handling:
  - lap_q registers lap each cycle; edge = lap & ~lap_q; hold toggles on edge.
  - hold_next = hold ^ edge.
  - Edge coinciding with COMMIT while entering hold: commit suppressed, so the frozen value is the previous commit.
  - Edge coinciding with COMMIT while leaving hold: commit applies in that same cycle.
  - Lap held high continuously produces exactly one toggle.
- Segment encoding:
  - HEX0..HEX4 from disp digits via a decoder. BCD values 10..15 are unreachable; the decoder maps them to blank.
  - HEX5 shows "L" when hold=1, blank otherwise.
  - dp lit only on HEX3.
  - All outputs are registered off disp/hold: changes appear on the cycle after COMMIT or toggle.
- Reset mid-conversion: immediate return to reset values; the next cycle after release is IDLE.

Optional Feature:
CHRONO_DISPLAY_LZB_EN.
- Defined: leading-zero blanking. HEX4 is blank when sec tens=0; HEX3 digit always shown. ms digits are never blanked.
- Undefined: all five digits are always shown. Reset display is "00.000".

Decomposition:
- Shared package chrono_pkg:
  - state encoding IDLE/LOAD/SHIFT/COMMIT
  - N_SHIFT=10
  - seven-seg constants SEG_0..SEG_9, SEG_BLANK, SEG_L (a..g, active-high form; polarity applied at output)
- One natural sub-module: bcd_to_7seg (4-bit in, 7-bit out, combinational), instantiated 5 times.
- FSM and double-dabble stay in chrono_display.

Test Plan:
- Reset, then 12 cycles with ms=0, sec=0 -> HEX4..HEX0 = "0","0","0","0","0"; dp on HEX3 only; HEX5 blank; conv_done pulses every 12 cycles.
- ms=999, sec=59 held constant -> after first COMMIT, digits 5,9,9,9,9; next conversion unchanged.
- ms=1023, sec=63 (out of range) -> displays 59.999.
- ms=307, sec=8; single lap pulse mid-SHIFT; inputs then change to 512/30 -> display stays 08.307 with HEX5="L"; second lap pulse -> next COMMIT shows 30.512 and HEX5 blank.
- Lap edge in the COMMIT cycle with new value 12.345 (previous 11.111, hold=0) -> hold=1, display remains 11.111.
- Assert rst_a_p during SHIFT with 45.678 displayed -> immediately "00.000", hold=0. With CHRONO_DISPLAY_LZB_EN defined, reset shows HEX4 blank.
